vga_tile_scanner: RTL and testbench
===================================

// Module: vga_tile_scanner
// PURPOSE
//  Raster source for the Pong game-board consumers (ball, paddles, score). Runs the
//  640x480@60 VGA column/row counters, generates HSync/VSync/Active, and emits the
//  tile-divided column/row indices that the ball and paddle draw logic compare against.
//  A programmable delay line re-aligns syncs with the consumers' registered draw outputs.
// PARAMETERS
//  c_TOTAL_COLS    800  pixels per line incl. blanking
//  c_TOTAL_ROWS    525  lines per frame incl. blanking
//  c_ACTIVE_COLS   640  visible pixels per line
//  c_ACTIVE_ROWS   480  visible lines per frame
//  c_H_FRONT       16   h front porch (pixels)
//  c_H_SYNC        96   h sync width (pixels)
//  c_V_FRONT       10   v front porch (lines)
//  c_V_SYNC        2    v sync width (lines)
//  c_TILE_SHIFT    4    log2 tile size; 16-px tiles -> 40x30 board
//  c_SYNC_DLY      1    extra cycles on o_*_Dly outputs (0..7; 0 = passthrough)
// PORTS
//  i_Clk            in   1  pixel clock (25 MHz)
//  i_Rst            in   1  synchronous reset, active-high
//  o_HSync          out  1  horizontal sync, active-low, registered
//  o_VSync          out  1  vertical sync, active-low, registered
//  o_Active         out  1  1 while col<c_ACTIVE_COLS and row<c_ACTIVE_ROWS
//  o_Col_Count_Div  out  6  col>>c_TILE_SHIFT in active area, else 6'h3F
//  o_Row_Count_Div  out  6  row>>c_TILE_SHIFT in active area, else 6'h3F
//  o_Frame_Start    out  1  one-cycle pulse coincident with pixel (0,0)
//  o_HSync_Dly      out  1  o_HSync delayed c_SYNC_DLY cycles
//  o_VSync_Dly      out  1  o_VSync delayed c_SYNC_DLY cycles
//  o_Active_Dly     out  1  o_Active delayed c_SYNC_DLY cycles
// BEHAVIOUR
//  - One clock, i_Clk; reset synchronous active-high on i_Rst; all state on posedge.
//  - Reset values: col=0,row=0; o_HSync=1,o_VSync=1,o_Active=0,o_Frame_Start=0,
//    Div outputs=6'h3F; every delay-line stage: HSync/VSync=1, Active=0.
//  - Col counter 10b: increments every cycle; at c_TOTAL_COLS-1 wraps to 0 and row
//    increments. Row 10b: at c_TOTAL_ROWS-1 with col wrap, wraps to 0. No enable.
//  - Outputs are registered decodes of the counter: latency 1 cycle from counter value.
//  - o_HSync=0 iff c_ACTIVE_COLS+c_H_FRONT <= col < c_ACTIVE_COLS+c_H_FRONT+c_H_SYNC
//    (656..751). o_VSync=0 iff 490<=row<492 (same form). Boundaries inclusive/exclusive
//    exactly as written.
//  - Div outputs forced to 6'h3F outside active area so no game object (X,Y<=39,29)
//    ever matches during blanking. Inside: col[9:4], row[9:4] truncated to 6 bits.
//  - o_Frame_Start=1 for exactly one cycle per frame, same cycle o_Active first rises.
//  - Delay line: c_SYNC_DLY-deep shift register per signal; c_SYNC_DLY=0 -> Dly
//    outputs equal undelayed outputs combinationally. Default 1 matches the one-cycle
//    registered draw output of the ball/paddle blocks.
//  - Reset mid-frame: next cycle counters=0 and all outputs at reset values; first
//    o_Frame_Start after release appears 1 cycle after the first un-reset edge.
//  - Frame period exactly c_TOTAL_COLS*c_TOTAL_ROWS = 420000 cycles.
// STRUCTURE
//  - Shared package pong_pkg: VGA 640x480 timing constants, c_TILE_SHIFT, board size
//    (40x30), 6'h3F off-board sentinel.
//  - One sub-module: sync_delay_line (width, depth, reset value params) instantiated
//    for {HSync,VSync,Active}.
// TESTING
//  1 Reset 3 cycles, release -> cycle 1: HSync=VSync=1, Active=1, Frame_Start=1, Div=0/0.
//  2 Run one line -> HSync low for exactly 96 cycles starting at col 656; Active low 160.
//  3 Run one frame -> VSync low for 2*800 cycles from row 490; next Frame_Start 420000 later.
//  4 At col 639 row 479 -> Div=39/29; col 640 -> Div=3F/3F; sweep never shows X>39 in active.
//  5 c_SYNC_DLY=0,1,3 -> Dly outputs lag undelayed by exactly 0,1,3 cycles; reset values hold.
//  6 Assert i_Rst at row 200 col 300 for 1 cycle -> counters restart at 0, outputs idle, new frame.

Source files
------------

// File: rtl/pong_pkg.sv
// pong_pkg: shared VGA 640x480 timing, tile geometry and game-board constants
package pong_pkg;
    localparam int c_VGA_TOTAL_COLS  = 800;
    localparam int c_VGA_TOTAL_ROWS  = 525;
    localparam int c_VGA_ACTIVE_COLS = 640;
    localparam int c_VGA_ACTIVE_ROWS = 480;
    localparam int c_VGA_H_FRONT     = 16;
    localparam int c_VGA_H_SYNC      = 96;
    localparam int c_VGA_V_FRONT     = 10;
    localparam int c_VGA_V_SYNC      = 2;
    localparam int c_TILE_SHIFT      = 4;
    localparam int c_BOARD_COLS      = 40;
    localparam int c_BOARD_ROWS      = 30;
    localparam logic [5:0] c_OFF_BOARD = 6'h3F;
    typedef struct packed {
        logic hsync;
        logic vsync;
        logic active;
    } sync_t;
    localparam sync_t c_SYNC_IDLE = '{hsync: 1'b1, vsync: 1'b1, active: 1'b0};
endpackage

// File: rtl/sync_delay_line.sv
// sync_delay_line: fixed-depth shift register with reset value; depth 0 is a wire
module sync_delay_line #(
    parameter int c_WIDTH = 1,
    parameter int c_DEPTH = 1,
    parameter logic [c_WIDTH-1:0] c_RST_VAL = '0
) (
    input  logic               i_Clk,
    input  logic               i_Rst,
    input  logic [c_WIDTH-1:0] i_Data,
    output logic [c_WIDTH-1:0] o_Data
);
    localparam int c_N = (c_DEPTH == 0) ? 1 : c_DEPTH;
    logic [c_WIDTH-1:0] r_pipe [c_N];
    // shift every cycle; reset loads the idle value into every stage
    always_ff @(posedge i_Clk)
        if (i_Rst) r_pipe <= '{default: c_RST_VAL};
        else begin
            r_pipe[0] <= i_Data;
            for (int k = 1; k < c_N; k++) r_pipe[k] <= r_pipe[k-1];
        end
    assign o_Data = (c_DEPTH == 0) ? i_Data : r_pipe[c_N-1];
endmodule

// File: rtl/vga_tile_scanner.sv
// vga_tile_scanner: VGA raster counters, registered syncs and tile indices for Pong
module vga_tile_scanner
    import pong_pkg::*;
#(
    parameter int c_TOTAL_COLS  = c_VGA_TOTAL_COLS,
    parameter int c_TOTAL_ROWS  = c_VGA_TOTAL_ROWS,
    parameter int c_ACTIVE_COLS = c_VGA_ACTIVE_COLS,
    parameter int c_ACTIVE_ROWS = c_VGA_ACTIVE_ROWS,
    parameter int c_H_FRONT     = c_VGA_H_FRONT,
    parameter int c_H_SYNC      = c_VGA_H_SYNC,
    parameter int c_V_FRONT     = c_VGA_V_FRONT,
    parameter int c_V_SYNC      = c_VGA_V_SYNC,
    parameter int c_SYNC_DLY    = 1
) (
    input  logic       i_Clk,
    input  logic       i_Rst,
    output logic       o_HSync,
    output logic       o_VSync,
    output logic       o_Active,
    output logic [5:0] o_Col_Count_Div,
    output logic [5:0] o_Row_Count_Div,
    output logic       o_Frame_Start,
    output logic       o_HSync_Dly,
    output logic       o_VSync_Dly,
    output logic       o_Active_Dly
);
    localparam logic [9:0] c_LAST_COL = 10'(c_TOTAL_COLS - 1);
    localparam logic [9:0] c_LAST_ROW = 10'(c_TOTAL_ROWS - 1);
    localparam logic [9:0] c_ACT_COLS = 10'(c_ACTIVE_COLS);
    localparam logic [9:0] c_ACT_ROWS = 10'(c_ACTIVE_ROWS);
    localparam logic [9:0] c_HS_BEG   = 10'(c_ACTIVE_COLS + c_H_FRONT);
    localparam logic [9:0] c_HS_END   = 10'(c_ACTIVE_COLS + c_H_FRONT + c_H_SYNC);
    localparam logic [9:0] c_VS_BEG   = 10'(c_ACTIVE_ROWS + c_V_FRONT);
    localparam logic [9:0] c_VS_END   = 10'(c_ACTIVE_ROWS + c_V_FRONT + c_V_SYNC);

    logic [9:0] r_col, r_row;
    logic       r_HSync, r_VSync, r_Active, r_Frame_Start;
    logic [5:0] r_Col_Div, r_Row_Div;
    logic       w_active, w_col_wrap;
    sync_t      w_sync, w_sync_dly;

    assign w_active   = (r_col < c_ACT_COLS) && (r_row < c_ACT_ROWS);
    assign w_col_wrap = (r_col == c_LAST_COL);

    // free-running column/row raster counters
    always_ff @(posedge i_Clk)
        if (i_Rst) begin
            r_col <= '0;
            r_row <= '0;
        end else begin
            r_col <= w_col_wrap ? '0 : r_col + 10'd1;
            if (w_col_wrap) r_row <= (r_row == c_LAST_ROW) ? '0 : r_row + 10'd1;
        end

    // registered decode of the counters; tile indices pinned off-board in blanking
    always_ff @(posedge i_Clk)
        if (i_Rst) begin
            r_HSync       <= 1'b1;
            r_VSync       <= 1'b1;
            r_Active      <= 1'b0;
            r_Frame_Start <= 1'b0;
            r_Col_Div     <= c_OFF_BOARD;
            r_Row_Div     <= c_OFF_BOARD;
        end else begin
            r_HSync       <= !((r_col >= c_HS_BEG) && (r_col < c_HS_END));
            r_VSync       <= !((r_row >= c_VS_BEG) && (r_row < c_VS_END));
            r_Active      <= w_active;
            r_Frame_Start <= (r_col == '0) && (r_row == '0);
            r_Col_Div     <= w_active ? 6'(r_col >> c_TILE_SHIFT) : c_OFF_BOARD;
            r_Row_Div     <= w_active ? 6'(r_row >> c_TILE_SHIFT) : c_OFF_BOARD;
        end

    assign w_sync = '{hsync: r_HSync, vsync: r_VSync, active: r_Active};

    sync_delay_line #(
        .c_WIDTH  (3),
        .c_DEPTH  (c_SYNC_DLY),
        .c_RST_VAL(c_SYNC_IDLE)
    ) u_sync_dly (
        .i_Clk (i_Clk),
        .i_Rst (i_Rst),
        .i_Data(w_sync),
        .o_Data(w_sync_dly)
    );

    assign o_HSync         = r_HSync;
    assign o_VSync         = r_VSync;
    assign o_Active        = r_Active;
    assign o_Frame_Start   = r_Frame_Start;
    assign o_Col_Count_Div = r_Col_Div;
    assign o_Row_Count_Div = r_Row_Div;
    assign o_HSync_Dly     = w_sync_dly.hsync;
    assign o_VSync_Dly     = w_sync_dly.vsync;
    assign o_Active_Dly    = w_sync_dly.active;
endmodule

// File: tb/tb_vga_tile_scanner.sv
// tb_vga_tile_scanner: scoreboard bench against a position-based raster model
module tb_vga_tile_scanner;
    typedef struct packed {
        logic hs, vs, act, fs;
        logic [5:0] cd, rd;
    } und_t;
    typedef struct packed {
        und_t u;
        logic hsd, vsd, actd;
    } obs_t;
    localparam und_t c_IDLE = '{hs: 1'b1, vs: 1'b1, act: 1'b0, fs: 1'b0, cd: 6'h3F, rd: 6'h3F};

    // instance 0: full 640x480 timing, delay 1; instances 1/2: short frames, delay 3 / 0
    int TR[3]  = '{525, 48, 48};
    int AR[3]  = '{480, 40, 40};
    int VS0[3] = '{490, 42, 42};
    int VS1[3] = '{492, 44, 44};
    int D[3]   = '{1, 3, 0};

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic done = 1'b0;
    logic [2:0] hs, vs, act, fs, hsd, vsd, actd;
    logic [5:0] cd [3];
    logic [5:0] rd [3];
    obs_t q [3][$];
    und_t h [3][$];
    int checks = 0;
    int errors = 0;
    int cyc = 0;

    always #5 clk = ~clk;

    vga_tile_scanner #(.c_SYNC_DLY(1)) dut0 (
        .i_Clk(clk), .i_Rst(rst), .o_HSync(hs[0]), .o_VSync(vs[0]), .o_Active(act[0]),
        .o_Col_Count_Div(cd[0]), .o_Row_Count_Div(rd[0]), .o_Frame_Start(fs[0]),
        .o_HSync_Dly(hsd[0]), .o_VSync_Dly(vsd[0]), .o_Active_Dly(actd[0]));

    vga_tile_scanner #(.c_TOTAL_ROWS(48), .c_ACTIVE_ROWS(40), .c_V_FRONT(2), .c_V_SYNC(2),
                       .c_SYNC_DLY(3)) dut1 (
        .i_Clk(clk), .i_Rst(rst), .o_HSync(hs[1]), .o_VSync(vs[1]), .o_Active(act[1]),
        .o_Col_Count_Div(cd[1]), .o_Row_Count_Div(rd[1]), .o_Frame_Start(fs[1]),
        .o_HSync_Dly(hsd[1]), .o_VSync_Dly(vsd[1]), .o_Active_Dly(actd[1]));

    vga_tile_scanner #(.c_TOTAL_ROWS(48), .c_ACTIVE_ROWS(40), .c_V_FRONT(2), .c_V_SYNC(2),
                       .c_SYNC_DLY(0)) dut2 (
        .i_Clk(clk), .i_Rst(rst), .o_HSync(hs[2]), .o_VSync(vs[2]), .o_Active(act[2]),
        .o_Col_Count_Div(cd[2]), .o_Row_Count_Div(rd[2]), .o_Frame_Start(fs[2]),
        .o_HSync_Dly(hsd[2]), .o_VSync_Dly(vsd[2]), .o_Active_Dly(actd[2]));

    // outputs expected for the n-th pixel position after reset release
    function automatic und_t decode(int n, int tr, int ar, int v0, int v1);
        int p, c, r;
        und_t u;
        p = n % (800 * tr);
        c = p % 800;
        r = p / 800;
        u.act = (c < 640) && (r < ar);
        u.hs  = !(c >= 656 && c < 752);
        u.vs  = !(r >= v0 && r < v1);
        u.fs  = (p == 0);
        u.cd  = u.act ? 6'(c / 16) : 6'h3F;
        u.rd  = u.act ? 6'(r / 16) : 6'h3F;
        return u;
    endfunction

    function automatic obs_t got(int i);
        obs_t o;
        o.u    = '{hs: hs[i], vs: vs[i], act: act[i], fs: fs[i], cd: cd[i], rd: rd[i]};
        o.hsd  = hsd[i];
        o.vsd  = vsd[i];
        o.actd = actd[i];
        return o;
    endfunction

    // stimulus: drive reset and push the expected post-edge outputs of every instance
    initial begin
        int n[3], s[3];
        int r1, total;
        und_t u, d;
        obs_t e;
        n = '{0, 0, 0};
        s = '{0, 0, 0};
        r1 = int'($urandom_range(1200, 2400));
        total = r1 + 41000;
        for (int k = 0; k < total; k++) begin
            rst = (k < 3) || (k == r1);
            for (int i = 0; i < 3; i++) begin
                if (rst) begin
                    u = c_IDLE;
                    n[i] = 0;
                    s[i] = 0;
                end else begin
                    u = decode(n[i], TR[i], AR[i], VS0[i], VS1[i]);
                    n[i]++;
                    s[i] = (s[i] < 8) ? s[i] + 1 : 8;
                end
                h[i].push_front(u);
                if (h[i].size() > 8) void'(h[i].pop_back());
                d = (s[i] >= D[i]) ? h[i][D[i]] : c_IDLE;
                e.u = u;
                e.hsd = d.hs;
                e.vsd = d.vs;
                e.actd = d.act;
                q[i].push_back(e);
            end
            @(negedge clk);
        end
        done = 1'b1;
        #20;
        for (int i = 0; i < 3; i++) begin
            checks++;
            if (q[i].size() != 0) begin
                errors++;
                $display("FAIL drain inst%0d: %0d expectations left, expected 0", i, q[i].size());
            end
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    // monitor: after every edge pop one expectation per instance and compare
    initial begin
        obs_t g, x;
        forever begin
            @(posedge clk);
            #1;
            if (done) break;
            cyc++;
            for (int i = 0; i < 3; i++) begin
                checks++;
                if (q[i].size() == 0) begin
                    errors++;
                    $display("FAIL underflow inst%0d cycle %0d: no expectation queued", i, cyc);
                end else begin
                    x = q[i].pop_front();
                    g = got(i);
                    if (g !== x) begin
                        errors++;
                        $display("FAIL inst%0d cycle %0d: got hs=%b vs=%b act=%b fs=%b cd=%0d rd=%0d dly=%b%b%b expected hs=%b vs=%b act=%b fs=%b cd=%0d rd=%0d dly=%b%b%b",
                                 i, cyc, g.u.hs, g.u.vs, g.u.act, g.u.fs, g.u.cd, g.u.rd, g.hsd, g.vsd, g.actd,
                                 x.u.hs, x.u.vs, x.u.act, x.u.fs, x.u.cd, x.u.rd, x.hsd, x.vsd, x.actd);
                    end
                end
            end
        end
    end
endmodule
